// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and helpers for the hazard/forwarding scoreboard.
//   sb_entry_t  : one tracked writer (valid, destination register, load flag)
//   FWD_SEL_RF  : forwarding select meaning "use the ID/EX register value"
//   fwd_ready() : whether a writer found at a stage can forward to a consumer
//                 that is entering EX.
package hazard_pkg;

  // Widest register address the entry type can hold; narrower addresses
  // are zero-extended into it.
  localparam int RD_MAX_W = 8;

  localparam int FWD_SEL_RF = 0;

  typedef struct packed {
    logic                valid;
    logic [RD_MAX_W-1:0] rd;
    logic                is_load;
  } sb_entry_t;

  // A producer matched at stage_idx sits at stage_idx+1 once the consumer
  // is in EX. Non-load results exist from stage 1 on; load data only from
  // load_ready_stage on.
  function automatic logic fwd_ready(input int   stage_idx,
                                     input logic is_load,
                                     input int   load_ready_stage);
    return !is_load || ((stage_idx + 1) >= load_ready_stage);
  endfunction

endpackage

// File: rtl/hazard_src_check.sv
// hazard_src_check: compares one decode-stage source against the tracked
// writers and returns the load-use hazard flag and the forwarding select.
//   src_addr_i : source register address
//   src_used_i : source is actually read
//   entries_i  : tracked writers, index 0 = EX
//   hazard_o   : youngest matching writer is a load whose data is not ready
//   sel_o      : forwarding select (0 = register value, k = stage k output)
module hazard_src_check
  import hazard_pkg::*;
#(
  parameter int NUM_STAGES       = 3,
  parameter int REG_ADDR_W       = 5,
  parameter int LOAD_READY_STAGE = 2,
  parameter int SEL_W            = $clog2(NUM_STAGES)
) (
  input  logic [REG_ADDR_W-1:0] src_addr_i,
  input  logic                  src_used_i,
  input  sb_entry_t             entries_i [NUM_STAGES],
  output logic                  hazard_o,
  output logic [SEL_W-1:0]      sel_o
);

  logic found;

  // Scan from youngest (stage 0) to oldest; the first hit wins. The last
  // stage is skipped because the register file writes through.
  always_comb begin
    hazard_o = 1'b0;
    sel_o    = SEL_W'(FWD_SEL_RF);
    found    = 1'b0;
    if (src_used_i && (src_addr_i != '0)) begin
      for (int k = 0; k < NUM_STAGES - 1; k++) begin
        if (!found && entries_i[k].valid &&
            (entries_i[k].rd == RD_MAX_W'(src_addr_i))) begin
          found = 1'b1;
          if (fwd_ready(k, entries_i[k].is_load, LOAD_READY_STAGE)) begin
            sel_o = SEL_W'(k + 1);
          end else begin
            hazard_o = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks in-flight register writers through NUM_STAGES
// post-decode stages, raises the load-use stall/bubble and produces
// registered forwarding selects aligned with the instruction's EX cycle.
//   clk, rst            : clock, asynchronous active-high reset
//   id_*                : decode-stage instruction description
//   flush               : kill the ID instruction
//   ext_stall           : freeze all state this cycle
//   stall, bubble       : hold PC/IF-ID and insert NOP into ID/EX (equal)
//   ex_fwd_sel          : per-source forwarding selects for the EX instruction
//   stage_valid         : per-stage valid writer flags
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NUM_STAGES       = 3,
  parameter int NUM_SRC          = 2,
  parameter int REG_ADDR_W       = 5,
  parameter int LOAD_READY_STAGE = 2,
  parameter int SEL_W            = $clog2(NUM_STAGES)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          id_valid,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] id_src_addr,
  input  logic [NUM_SRC-1:0]            id_src_used,
  input  logic [REG_ADDR_W-1:0]         id_rd,
  input  logic                          id_regwrite,
  input  logic                          id_is_load,
  input  logic                          flush,
  input  logic                          ext_stall,
  output logic                          stall,
  output logic                          bubble,
  output logic [NUM_SRC*SEL_W-1:0]      ex_fwd_sel,
  output logic [NUM_STAGES-1:0]         stage_valid
);

  sb_entry_t                stage_q [NUM_STAGES];
  sb_entry_t                stage_d [NUM_STAGES];
  logic [NUM_SRC*SEL_W-1:0] fwd_sel_q, fwd_sel_d;
  logic [NUM_SRC*SEL_W-1:0] cand_sel;
  logic [NUM_SRC-1:0]       src_hazard;
  sb_entry_t                id_entry;
  logic                     accept;

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    hazard_src_check #(
      .NUM_STAGES      (NUM_STAGES),
      .REG_ADDR_W      (REG_ADDR_W),
      .LOAD_READY_STAGE(LOAD_READY_STAGE),
      .SEL_W           (SEL_W)
    ) u_check (
      .src_addr_i(id_src_addr[gi*REG_ADDR_W +: REG_ADDR_W]),
      .src_used_i(id_src_used[gi]),
      .entries_i (stage_q),
      .hazard_o  (src_hazard[gi]),
      .sel_o     (cand_sel[gi*SEL_W +: SEL_W])
    );
  end

  for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_valid
    assign stage_valid[gi] = stage_q[gi].valid;
  end

  // Writes to r0 are architecturally discarded, so they are never tracked.
  always_comb begin
    id_entry.valid   = id_regwrite && (id_rd != '0);
    id_entry.rd      = RD_MAX_W'(id_rd);
    id_entry.is_load = id_is_load;
  end

  assign stall  = id_valid && (|src_hazard) && !flush && !ext_stall;
  assign bubble = stall;
  assign accept = id_valid && !stall && !flush;

  always_comb begin
    stage_d[0] = accept ? id_entry : '0;
    for (int i = 1; i < NUM_STAGES; i++) begin
      stage_d[i] = stage_q[i-1];
    end
    fwd_sel_d = accept ? cand_sel : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_STAGES; i++) begin
        stage_q[i] <= '0;
      end
      fwd_sel_q <= '0;
    end else if (!ext_stall) begin
      for (int i = 0; i < NUM_STAGES; i++) begin
        stage_q[i] <= stage_d[i];
      end
      fwd_sel_q <= fwd_sel_d;
    end
  end

  assign ex_fwd_sel = fwd_sel_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

  localparam int K_STALL = 0;
  localparam int K_SEL   = 1;
  localparam int K_SV    = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // DUT A: default parameters
  logic        a_valid, a_rw, a_ld, a_fl, a_es;
  logic [9:0]  a_src;
  logic [1:0]  a_used;
  logic [4:0]  a_rd;
  logic        a_stall, a_bubble;
  logic [3:0]  a_sel;
  logic [2:0]  a_sv;

  // DUT B: NUM_STAGES=5, LOAD_READY_STAGE=3
  logic        b_valid, b_rw, b_ld, b_fl, b_es;
  logic [9:0]  b_src;
  logic [1:0]  b_used;
  logic [4:0]  b_rd;
  logic        b_stall, b_bubble;
  logic [5:0]  b_sel;
  logic [4:0]  b_sv;

  hazard_scoreboard u_dut_a (
    .clk(clk), .rst(rst), .id_valid(a_valid), .id_src_addr(a_src),
    .id_src_used(a_used), .id_rd(a_rd), .id_regwrite(a_rw),
    .id_is_load(a_ld), .flush(a_fl), .ext_stall(a_es),
    .stall(a_stall), .bubble(a_bubble), .ex_fwd_sel(a_sel),
    .stage_valid(a_sv)
  );

  hazard_scoreboard #(.NUM_STAGES(5), .LOAD_READY_STAGE(3)) u_dut_b (
    .clk(clk), .rst(rst), .id_valid(b_valid), .id_src_addr(b_src),
    .id_src_used(b_used), .id_rd(b_rd), .id_regwrite(b_rw),
    .id_is_load(b_ld), .flush(b_fl), .ext_stall(b_es),
    .stall(b_stall), .bubble(b_bubble), .ex_fwd_sel(b_sel),
    .stage_valid(b_sv)
  );

  typedef struct {
    int          cyc;
    int          dut;
    int          kind;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] actual(input int dut, input int kind);
    logic [31:0] v;
    v = '0;
    case (kind)
      K_STALL: v = dut == 0 ? {30'd0, a_bubble, a_stall} : {30'd0, b_bubble, b_stall};
      K_SEL:   v = dut == 0 ? {28'd0, a_sel} : {26'd0, b_sel};
      default: v = dut == 0 ? {29'd0, a_sv} : {27'd0, b_sv};
    endcase
    return v;
  endfunction

  // Monitor: every cycle, compare all expectations due this cycle.
  always @(negedge clk) begin
    int i;
    logic [31:0] act, req;
    i = 0;
    while (i < exp_q.size()) begin
      if (exp_q[i].cyc == cyc) begin
        act = actual(exp_q[i].dut, exp_q[i].kind);
        req = exp_q[i].kind == K_STALL ? {30'd0, exp_q[i].val[0], exp_q[i].val[0]}
                                       : exp_q[i].val;
        total++;
        if (act !== req) begin
          bad++;
          $display("FAIL %s cyc=%0d actual=%0h required=%0h", exp_q[i].name, cyc, act, req);
        end else begin
          $display("check %s cyc=%0d value=%0h ok", exp_q[i].name, cyc, act);
        end
        exp_q.delete(i);
      end else begin
        i++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_v(input int dly, input int dut, input int kind,
                          input logic [31:0] v, input string nm);
    exp_t e;
    e.cyc = cyc + dly; e.dut = dut; e.kind = kind; e.val = v; e.name = nm;
    exp_q.push_back(e);
  endtask

  task automatic set_a(input logic v, input logic [4:0] s0, input logic [4:0] s1,
                       input logic [1:0] used, input logic [4:0] rd, input logic rw,
                       input logic ld, input logic fl, input logic es);
    a_valid = v; a_src = {s1, s0}; a_used = used; a_rd = rd;
    a_rw = rw; a_ld = ld; a_fl = fl; a_es = es;
  endtask

  task automatic set_b(input logic v, input logic [4:0] s0, input logic [4:0] s1,
                       input logic [1:0] used, input logic [4:0] rd, input logic rw,
                       input logic ld, input logic fl, input logic es);
    b_valid = v; b_src = {s1, s0}; b_used = used; b_rd = rd;
    b_rw = rw; b_ld = ld; b_fl = fl; b_es = es;
  endtask

  task automatic idle_a(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      set_a(0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    end
  endtask

  task automatic idle_b(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      set_b(0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    end
  endtask

  initial begin
    set_a(0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    set_b(0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    tick();
    tick();
    rst = 1'b0;
    expect_v(0, 0, K_STALL, 0, "rst_a_stall");
    expect_v(0, 0, K_SEL,   0, "rst_a_sel");
    expect_v(0, 0, K_SV,    0, "rst_a_sv");
    expect_v(0, 1, K_STALL, 0, "rst_b_stall");
    expect_v(0, 1, K_SEL,   0, "rst_b_sel");
    expect_v(0, 1, K_SV,    0, "rst_b_sv");

    // ALU back-to-back: add r3 then read r3
    tick(); set_a(1, 1, 2, 2'b00, 3, 1, 0, 0, 0);
    expect_v(0, 0, K_STALL, 0, "b2b_add_stall");
    tick(); set_a(1, 3, 0, 2'b01, 10, 0, 0, 0, 0);
    expect_v(0, 0, K_STALL, 0, "b2b_use_stall");
    expect_v(0, 0, K_SV, 3'b001, "b2b_sv");
    expect_v(1, 0, K_SEL, 4'b0001, "b2b_sel");
    tick(); set_a(0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    expect_v(0, 0, K_SV, 3'b010, "b2b_sv_next");
    idle_a(2);

    // Distance 2 -> select 2
    tick(); set_a(1, 0, 0, 2'b00, 3, 1, 0, 0, 0);
    idle_a(1);
    tick(); set_a(1, 3, 0, 2'b01, 10, 0, 0, 0, 0);
    expect_v(0, 0, K_STALL, 0, "dist2_stall");
    expect_v(1, 0, K_SEL, 4'b0010, "dist2_sel");
    idle_a(3);

    // Distance 3 -> writer in WB is ignored, select 0
    tick(); set_a(1, 0, 0, 2'b00, 6, 1, 0, 0, 0);
    idle_a(2);
    tick(); set_a(1, 6, 0, 2'b01, 10, 0, 0, 0, 0);
    expect_v(0, 0, K_STALL, 0, "dist3_stall");
    expect_v(0, 0, K_SV, 3'b100, "dist3_sv");
    expect_v(1, 0, K_SEL, 4'b0000, "dist3_sel");
    idle_a(3);

    // Load-use on src1: one stall cycle then select 2
    tick(); set_a(1, 0, 0, 2'b00, 5, 1, 1, 0, 0);
    tick(); set_a(1, 1, 5, 2'b10, 11, 0, 0, 0, 0);
    expect_v(0, 0, K_STALL, 1, "lu_stall1");
    tick();
    expect_v(0, 0, K_STALL, 0, "lu_stall2");
    expect_v(0, 0, K_SV, 3'b010, "lu_bubble_sv");
    expect_v(0, 0, K_SEL, 4'b0000, "lu_bubble_sel");
    expect_v(1, 0, K_SEL, 4'b1000, "lu_sel");
    tick(); set_a(0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    expect_v(0, 0, K_SV, 3'b100, "lu_sv_after");
    idle_a(2);

    // Youngest wins, then r0 never tracked
    tick(); set_a(1, 0, 0, 2'b00, 4, 1, 0, 0, 0);
    tick(); set_a(1, 0, 0, 2'b00, 4, 1, 0, 0, 0);
    tick(); set_a(1, 4, 0, 2'b01, 10, 0, 0, 0, 0);
    expect_v(0, 0, K_STALL, 0, "young_stall");
    expect_v(1, 0, K_SEL, 4'b0001, "young_sel");
    tick(); set_a(1, 0, 0, 2'b00, 0, 1, 0, 0, 0);
    tick(); set_a(1, 0, 0, 2'b01, 10, 0, 0, 0, 0);
    expect_v(0, 0, K_STALL, 0, "r0_stall");
    expect_v(0, 0, K_SV, 3'b100, "r0_sv");
    expect_v(1, 0, K_SEL, 4'b0000, "r0_sel");
    idle_a(3);

    // Flush with a hazard present
    tick(); set_a(1, 0, 0, 2'b00, 7, 1, 1, 0, 0);
    tick(); set_a(1, 7, 0, 2'b01, 9, 1, 0, 1, 0);
    expect_v(0, 0, K_STALL, 0, "flush_stall");
    tick(); set_a(0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    expect_v(0, 0, K_SV, 3'b010, "flush_sv");
    expect_v(0, 0, K_SEL, 4'b0000, "flush_sel");
    idle_a(2);

    // ext_stall held 3 cycles freezes everything
    tick(); set_a(1, 0, 0, 2'b00, 3, 1, 0, 0, 0);
    tick(); set_a(1, 3, 0, 2'b01, 8, 1, 1, 0, 0);
    expect_v(1, 0, K_SEL, 4'b0001, "es_pre_sel");
    for (int i = 0; i < 3; i++) begin
      tick(); set_a(1, 8, 0, 2'b01, 12, 0, 0, 0, 1);
      expect_v(0, 0, K_STALL, 0, "es_stall");
      expect_v(1, 0, K_SV, 3'b011, "es_sv_frozen");
      expect_v(1, 0, K_SEL, 4'b0001, "es_sel_frozen");
    end
    tick(); set_a(1, 8, 0, 2'b01, 12, 0, 0, 0, 0);
    expect_v(0, 0, K_STALL, 1, "es_release_stall");
    tick();
    expect_v(0, 0, K_STALL, 0, "es_resume_stall");
    expect_v(0, 0, K_SV, 3'b110, "es_resume_sv");
    tick(); set_a(0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    expect_v(0, 0, K_SV, 3'b100, "es_after_sv");
    expect_v(0, 0, K_SEL, 4'b0010, "es_after_sel");
    idle_a(3);

    // DUT B: load needs two stall cycles, then select 3
    tick(); set_b(1, 0, 0, 2'b00, 5, 1, 1, 0, 0);
    tick(); set_b(1, 5, 0, 2'b01, 10, 0, 0, 0, 0);
    expect_v(0, 1, K_STALL, 1, "b_lu_stall1");
    tick();
    expect_v(0, 1, K_STALL, 1, "b_lu_stall2");
    expect_v(0, 1, K_SV, 5'b00010, "b_lu_sv1");
    tick();
    expect_v(0, 1, K_STALL, 0, "b_lu_stall3");
    expect_v(0, 1, K_SV, 5'b00100, "b_lu_sv2");
    expect_v(0, 1, K_SEL, 6'b000000, "b_lu_sel_bubble");
    tick(); set_b(0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    expect_v(0, 1, K_SEL, 6'b000011, "b_lu_sel");
    idle_b(5);

    // Reset pulsed mid-stall acts immediately
    tick();
    set_a(1, 0, 0, 2'b00, 3, 1, 0, 0, 0);
    set_b(1, 0, 0, 2'b00, 6, 1, 1, 0, 0);
    tick();
    set_a(1, 3, 0, 2'b01, 10, 0, 0, 0, 0);
    set_b(1, 6, 0, 2'b01, 10, 0, 0, 0, 0);
    expect_v(0, 1, K_STALL, 1, "rst_pre_stall");
    tick();
    rst = 1'b1;
    expect_v(0, 0, K_SEL, 0, "rst_mid_a_sel");
    expect_v(0, 0, K_SV, 0, "rst_mid_a_sv");
    expect_v(0, 1, K_STALL, 0, "rst_mid_b_stall");
    expect_v(0, 1, K_SV, 0, "rst_mid_b_sv");
    tick();
    rst = 1'b0;
    set_a(0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    set_b(0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    expect_v(0, 0, K_SV, 0, "rst_post_a_sv");
    expect_v(0, 1, K_SV, 0, "rst_post_b_sv");

    tick();
    tick();
    tick();
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL leftover_expectations actual=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard and forwarding controller for the pipelined MIPS core. It replaces the fixed two-operand forwarding and hazard detection pair with one block. The block tracks every in-flight register writer through a configurable number of post-decode stages and compares the decode-stage instruction's sources against them. It drives three things: the load-use stall/bubble, and registered forwarding selects that are valid when that instruction occupies EX.

## Interface
Parameters:
- NUM_STAGES, 3: tracked stages after ID; index 0 = EX, NUM_STAGES-1 = WB; legal range 2..8.
- NUM_SRC, 2: source operands per instruction.
- REG_ADDR_W, 5: register address width.
- LOAD_READY_STAGE, 2: first stage index where load data is forwardable; legal range 1..NUM_STAGES-1.
- SEL_W, $clog2(NUM_STAGES): width of one forwarding select (derived; do not override).

Ports (clock and reset first):
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_valid  in  1  a real instruction is in ID.
- id_src_addr  in  NUM_SRC*REG_ADDR_W  source register addresses; src j at [j*REG_ADDR_W +: REG_ADDR_W].
- id_src_used  in  NUM_SRC  bit j: source j is actually read.
- id_rd  in  REG_ADDR_W  destination register.
- id_regwrite  in  1  instruction writes id_rd.
- id_is_load  in  1  instruction is a load.
- flush  in  1  kill the ID instruction (taken branch/jump).
- ext_stall  in  1  global freeze (memory wait).
- stall  out  1  hold PC and IF/ID this cycle.
- bubble  out  1  insert NOP into ID/EX; always equal to stall.
- ex_fwd_sel  out  NUM_SRC*SEL_W  per-source select for the instruction in EX. 0 = ID/EX register value; k (1..NUM_STAGES-1) = result held in stage k's output register.
- stage_valid  out  NUM_STAGES  per-stage valid writer flags (debug/verification).

## Operation
- Per-stage entry: valid, rd, is_load. An entry is valid only if the instruction writes a register and its rd is nonzero.
- Hazard check (combinational), per source j:
  - Sources with id_src_used[j]=0 or address 0 never match.
  - Search stages 0..NUM_STAGES-2 for valid entries whose rd equals the source; the youngest match (lowest k) wins.
  - Stage NUM_STAGES-1 is ignored; the register file is write-through.
- Readiness of a match at k: the producer sits at k+1 when the consumer is in EX.
  - Ready if k+1 >= 1 for non-loads (always true).
  - Ready if k+1 >= LOAD_READY_STAGE for loads.
  - Ready: candidate select = k+1. Not ready: load-use hazard.
  - No match: candidate select = 0.
- stall = id_valid & any source hazard & !flush & !ext_stall.
- Clock edge, in priority order:
  - ext_stall=1: all state frozen, including ex_fwd_sel; flush is ignored that cycle, and the controller holds it.
  - Otherwise: stage[i] <= stage[i-1] for i >= 1.
  - stage[0] <= ID entry if id_valid & !stall & !flush, else an empty entry (bubble).
  - ex_fwd_sel <= candidate selects if an ID entry was accepted, else all zeros.
- Flush does not affect older in-flight entries; they keep advancing.

## Timing
- Reset: all stage entries invalid, ex_fwd_sel = 0, stall = bubble = 0. Reset takes effect immediately, including mid-stall.
- stall and bubble are combinational from the ID inputs and current state, with zero-cycle latency.
- ex_fwd_sel has one-cycle latency: it is registered and aligned with the instruction's EX cycle.
- Load-use with default parameters costs exactly 1 stall cycle. In general the cost is LOAD_READY_STAGE-1-k cycles for a load at stage k.
- An entry leaves the scoreboard NUM_STAGES cycles after acceptance, excluding ext_stall cycles.

## Structure
- Shared package hazard_pkg holds:
  - typedef sb_entry_t {valid, rd, is_load};
  - constant FWD_SEL_RF = 0;
  - function fwd_ready(stage_idx, is_load, load_ready_stage).
- Natural sub-module: hazard_src_check. One instance per source, generated NUM_SRC times; it maps one source address plus the entry array to {hazard, sel}.

## Test plan
Default parameters unless stated.
- ALU back-to-back: add r3 accepted, then ID reads r3 -> stall=0; next cycle ex_fwd_sel[src0] = 1.
- Distance 2: add r3, nop, sub reads r3 -> ex_fwd_sel = 2. Distance 3 -> ex_fwd_sel = 0 (register file path).
- Load-use: lw r5, then ID reads r5 as src1 -> stall=1 for exactly one cycle, stage_valid shows the bubble, then ex_fwd_sel[src1] = 2.
- Youngest wins and r0: add r4, add r4, then a read of r4 -> sel 1. A writer to r0 followed by a read of r0 -> no stall, sel 0.
- Flush/ext_stall:
  - flush with a hazard present -> stall=0, stage[0] empty, older entries advance.
  - ext_stall held 3 cycles -> stage_valid and ex_fwd_sel unchanged.
  - rst pulsed mid-stall -> all outputs 0 immediately.
- NUM_STAGES=5, LOAD_READY_STAGE=3: load then dependent read -> 2 stall cycles, then sel 3.
